// File: rtl/regfile_dbg_access_pkg.sv
// Shared state encoding and sizing helpers for the debug register-file initiator.
package regfile_dbg_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_WAIT,
    ST_ACCESS,
    ST_RESP,
    ST_HOLD,
    ST_RELEASE
  } dbg_state_e;

  // x0 is hardwired to zero in the architecture, so writes to it are dropped.
  localparam int X0_IDX = 0;

  function automatic int sel_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_dbg_access_sat_counter.sv
// Saturating up-counter with synchronous clear; done_o flags the last counted cycle.
module dbg_sat_counter
  import regfile_dbg_access_pkg::*;
#(
  parameter int LIMIT = 8,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/regfile_dbg_access.sv
// Debug-host initiator: halts the core, performs one register read or write, reports back.
module regfile_dbg_access
  import regfile_dbg_access_pkg::*;
#(
  parameter int WORD_SIZE    = 32,
  parameter int NUM_REGS     = 32,
  parameter int REG_SEL      = sel_width(NUM_REGS),
  parameter int HALT_TIMEOUT = 64,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [REG_SEL-1:0]   req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 halt_req,
  input  logic                 halt_ack,
  output logic [REG_SEL-1:0]   rf_rs,
  input  logic [WORD_SIZE-1:0] rf_rsData,
  output logic                 rf_wCtrl,
  output logic [REG_SEL-1:0]   rf_wSel,
  output logic [WORD_SIZE-1:0] rf_wData
);

  dbg_state_e           state_q;
  logic                 req_ready_q, resp_valid_q, resp_err_q, halt_req_q;
  logic                 rf_wCtrl_q, timed_out_q;
  logic [WORD_SIZE-1:0] resp_rdata_q, rf_wData_q;
  logic [REG_SEL-1:0]   rf_rs_q, rf_wSel_q;

  logic                 wr_q;
  logic [REG_SEL-1:0]   addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic                 accept, tmr_done, hold_done;
  logic                 acc_wr, acc_ok;
  logic [REG_SEL-1:0]   acc_addr;
  logic [WORD_SIZE-1:0] acc_wdata;

  function automatic logic in_range(input logic [REG_SEL-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign accept = req_valid && req_ready_q;

  // A request accepted in HOLD goes straight to ACCESS, so take its fields from the port.
  assign acc_wr    = (state_q == ST_HOLD) ? req_write : wr_q;
  assign acc_addr  = (state_q == ST_HOLD) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_HOLD) ? req_wdata : wdata_q;
  assign acc_ok    = in_range(acc_addr);

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      halt_req_q   <= 1'b0;
      rf_rs_q      <= '0;
      rf_wCtrl_q   <= 1'b0;
      rf_wSel_q    <= '0;
      rf_wData_q   <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            halt_req_q  <= 1'b1;
            timed_out_q <= 1'b0;
            state_q     <= ST_HALT_WAIT;
          end
        end
        ST_HALT_WAIT: begin
          if (halt_ack) begin
            state_q    <= ST_ACCESS;
            rf_rs_q    <= (!acc_wr && acc_ok) ? acc_addr : '0;
            rf_wCtrl_q <= acc_wr && acc_ok && (acc_addr != REG_SEL'(X0_IDX));
            rf_wSel_q  <= acc_wr ? acc_addr : '0;
            rf_wData_q <= acc_wr ? acc_wdata : '0;
          end else if (tmr_done) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            halt_req_q   <= 1'b0;
            timed_out_q  <= 1'b1;
          end
        end
        ST_ACCESS: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= !in_range(addr_q);
          resp_rdata_q <= (!wr_q && in_range(addr_q)) ? rf_rsData : '0;
          rf_rs_q      <= '0;
          rf_wCtrl_q   <= 1'b0;
          rf_wSel_q    <= '0;
          rf_wData_q   <= '0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (timed_out_q) begin
              state_q <= ST_RELEASE;
            end else begin
              state_q     <= ST_HOLD;
              req_ready_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (accept) begin
            state_q     <= ST_ACCESS;
            req_ready_q <= 1'b0;
            rf_rs_q     <= (!acc_wr && acc_ok) ? acc_addr : '0;
            rf_wCtrl_q  <= acc_wr && acc_ok && (acc_addr != REG_SEL'(X0_IDX));
            rf_wSel_q   <= acc_wr ? acc_addr : '0;
            rf_wData_q  <= acc_wr ? acc_wdata : '0;
          end else if (hold_done) begin
            state_q     <= ST_RELEASE;
            req_ready_q <= 1'b0;
            halt_req_q  <= 1'b0;
          end
        end
        ST_RELEASE: begin
          if (!halt_ack) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dbg_sat_counter #(.LIMIT(HALT_TIMEOUT)) u_halt_tmr (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (state_q != ST_HALT_WAIT),
    .en_i  (state_q == ST_HALT_WAIT),
    .done_o(tmr_done)
  );

  dbg_sat_counter #(.LIMIT(HOLD_CYCLES)) u_hold_tmr (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (state_q != ST_HOLD),
    .en_i  (state_q == ST_HOLD),
    .done_o(hold_done)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign halt_req   = halt_req_q;
  assign rf_rs      = rf_rs_q;
  assign rf_wCtrl   = rf_wCtrl_q;
  assign rf_wSel    = rf_wSel_q;
  assign rf_wData   = rf_wData_q;

endmodule

// File: tb/tb_regfile_dbg_access.sv
// Bench for regfile_dbg_access: core/regfile models, transaction-level reference, per-cycle checker.
module tb_regfile_dbg_access;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int RS = 5;
  localparam int HT = 64;
  localparam int HC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [RS-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [W-1:0]  resp_rdata;
  logic          halt_req, halt_ack;
  logic [RS-1:0] rf_rs, rf_wSel;
  logic [W-1:0]  rf_rsData, rf_wData;
  logic          rf_wCtrl;

  int   errors = 0;
  int   checks = 0;
  int   ack_lat;
  logic ack_en;
  int   halt_falls = 0;

  logic [W-1:0] regs [NR];
  logic [W-1:0] mdl  [NR];

  typedef struct {
    logic         wr;
    logic [RS-1:0] addr;
    logic [W-1:0] wdata;
    logic         err;
    logic [W-1:0] rdata;
    int           lat;
  } txn_t;
  txn_t q[$];

  always #5 clk = ~clk;

  regfile_dbg_access #(
    .WORD_SIZE(W), .NUM_REGS(NR), .HALT_TIMEOUT(HT), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_rs(rf_rs), .rf_rsData(rf_rsData),
    .rf_wCtrl(rf_wCtrl), .rf_wSel(rf_wSel), .rf_wData(rf_wData)
  );

  function automatic logic [W-1:0] init_val(input int i);
    if (i == 0) return '0;
    if (i == 5) return 32'hDEADBEEF;
    if (i == 9) return 32'h0BADF00D;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Register file seen by the block: combinational read, write on the rising edge.
  assign rf_rsData = regs[rf_rs];
  initial begin
    for (int i = 0; i < NR; i++) regs[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (rf_wCtrl) regs[rf_wSel] <= rf_wData;
    end
  end

  // Core: raises halt_ack ack_lat cycles after seeing halt_req, drops it once halt_req falls.
  initial begin
    int cnt;
    halt_ack = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!halt_req) begin
        halt_ack = 1'b0;
        cnt = 0;
      end else if (ack_en) begin
        if (cnt >= ack_lat) halt_ack = 1'b1;
        else cnt++;
      end
    end
  end

  // Reference model and per-cycle comparison.
  initial begin
    txn_t t;
    int   lat_ctr, hold_ctr, wp, exp_wp;
    logic seen, prev_wctrl, prev_hreq;
    logic [RS-1:0] wsel;
    logic [W-1:0]  wdat;
    for (int i = 0; i < NR; i++) mdl[i] = init_val(i);
    lat_ctr = 0; hold_ctr = -1; wp = 0; seen = 0; prev_wctrl = 0; prev_hreq = 0;
    wsel = '0; wdat = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        hold_ctr = -1; seen = 0; wp = 0; prev_wctrl = 0; prev_hreq = 0;
      end else begin
        lat_ctr++;
        if (prev_hreq && !halt_req) halt_falls++;
        prev_hreq = halt_req;
        if (hold_ctr >= 0) begin
          hold_ctr++;
          if (hold_ctr <= HC) chk("hold_halt_req", halt_req, 1'b1);
          else begin
            chk("release_halt_req", halt_req, 1'b0);
            hold_ctr = -1;
          end
        end
        if (rf_wCtrl) begin
          chk("wctrl_while_halted", halt_ack, 1'b1);
          chk("wctrl_single_cycle", prev_wctrl, 1'b0);
          chk("wctrl_not_x0", rf_wSel != '0, 1'b1);
          wp++; wsel = rf_wSel; wdat = rf_wData;
        end
        prev_wctrl = rf_wCtrl;
        if (req_ready) chk("req_ready_state", halt_req, halt_ack);
        if (resp_valid) begin
          chk("resp_blocks_req", req_ready, 1'b0);
          if (q.size() == 0) chk("resp_spurious", resp_valid, 1'b0);
          else begin
            if (!seen) begin
              chk("resp_latency", lat_ctr, q[0].lat);
              seen = 1;
            end
            chk("resp_err", resp_err, q[0].err);
            chk("resp_rdata", resp_rdata, q[0].rdata);
            if (q[0].err) chk("timeout_halt_req", halt_req, 1'b0);
            if (resp_ready) begin
              exp_wp = (q[0].wr && !q[0].err && q[0].addr != '0) ? 1 : 0;
              chk("wctrl_pulses", wp, exp_wp);
              if (exp_wp == 1) begin
                chk("wsel", wsel, q[0].addr);
                chk("wdata", wdat, q[0].wdata);
                mdl[q[0].addr] = q[0].wdata;
              end
              hold_ctr = q[0].err ? -1 : 0;
              void'(q.pop_front());
              seen = 0;
            end
          end
        end
        if (req_valid && req_ready) begin
          t.wr = req_write; t.addr = req_addr; t.wdata = req_wdata;
          t.err = !halt_ack && !ack_en;
          if (halt_ack)    t.lat = 2;
          else if (!ack_en) t.lat = HT + 1;
          else             t.lat = ack_lat + 3;
          t.rdata = (t.err || t.wr) ? '0 : mdl[t.addr];
          q.push_back(t);
          lat_ctr = 0; seen = 0; wp = 0; hold_ctr = -1;
        end
      end
    end
  end

  task automatic send(input logic w, input logic [RS-1:0] a, input logic [W-1:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (1) begin
      @(negedge clk); n++;
      if (req_ready) break;
      if (n > 200) begin
        chk("send_accept_timeout", req_ready, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic recv(input int hold_low, output logic [W-1:0] rd, output logic er);
    int n;
    n = 0; rd = '0; er = 1'b0;
    resp_ready = (hold_low == 0);
    do begin @(negedge clk); n++; end while (!resp_valid && n < 300);
    if (!resp_valid) begin
      chk("resp_wait_timeout", resp_valid, 1'b1);
      resp_ready = 1'b0;
    end else begin
      rd = resp_rdata; er = resp_err;
      if (hold_low > 0) begin
        repeat (hold_low) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  rd;
    logic          er, w;
    logic [RS-1:0] a;
    int            hf0, n;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; ack_en = 1'b1; ack_lat = 1;
    idle(3);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_halt_req", halt_req, 1'b0);
    chk("rst_wctrl", rf_wCtrl, 1'b0);
    chk("rst_rdata", resp_rdata, '0);
    chk("rst_rf_rs", rf_rs, '0);
    chk("rst_wsel", rf_wSel, '0);
    chk("rst_wdata", rf_wData, '0);
    rst = 1'b1;
    idle(2);
    chk("idle_req_ready", req_ready, 1'b1);

    // Read of a preloaded register, ack one cycle after halt_req.
    send(1'b0, 5'd5, '0);
    recv(0, rd, er);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_err", er, 1'b0);
    idle(12);

    // Write then immediate readback inside the hold window.
    send(1'b1, 5'd7, 32'h12345678);
    recv(0, rd, er);
    chk("t2_write_err", er, 1'b0);
    hf0 = halt_falls;
    send(1'b0, 5'd7, '0);
    recv(0, rd, er);
    chk("t2_readback", rd, 32'h12345678);
    chk("t2_no_rehandshake", halt_falls, hf0);
    chk("t2_regfile", regs[7], 32'h12345678);
    idle(12);

    // x0 write is dropped silently.
    send(1'b1, 5'd0, 32'hFFFFFFFF);
    recv(0, rd, er);
    chk("t3_write_err", er, 1'b0);
    send(1'b0, 5'd0, '0);
    recv(0, rd, er);
    chk("t3_x0_read", rd, '0);
    chk("t3_regfile_x0", regs[0], '0);
    idle(12);

    // Core never acknowledges.
    ack_en = 1'b0;
    send(1'b0, 5'd3, '0);
    recv(0, rd, er);
    chk("t4_err", er, 1'b1);
    chk("t4_rdata", rd, '0);
    ack_en = 1'b1;
    idle(4);

    // Host stalls the response for ten cycles.
    ack_lat = 0;
    send(1'b0, 5'd5, '0);
    recv(10, rd, er);
    chk("t5_rdata", rd, 32'hDEADBEEF);
    idle(12);

    // Reset while the write is on the regfile port.
    send(1'b1, 5'd9, 32'h55AA55AA);
    n = 0;
    do begin @(negedge clk); n++; end while (!rf_wCtrl && n < 20);
    chk("t6_reached_access", rf_wCtrl, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6_wctrl_drop", rf_wCtrl, 1'b0);
    chk("t6_halt_drop", halt_req, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("t6_idle_ready", req_ready, 1'b1);
    chk("t6_reg_unchanged", regs[9], 32'h0BADF00D);

    // Randomised traffic.
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? '0 : RS'($urandom_range(0, NR - 1));
      ack_lat = $urandom_range(0, 4);
      ack_en = ($urandom_range(0, 19) != 0);
      send(w, a, $urandom());
      recv($urandom_range(0, 3), rd, er);
      ack_en = 1'b1;
      idle($urandom_range(0, 12));
    end
    idle(15);

    for (int i = 0; i < NR; i++) chk("final_regfile", regs[i], mdl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dbg_access.md
Name: regfile_dbg_access

Overview:
- Debug-side initiator for the register file's read and write ports.
- Takes single-register read/write requests from the debug host over a valid/ready channel.
- Halts the core through a req/ack handshake, then drives the regfile ports itself. While halted, the top level muxes this block's rf_* signals onto the regfile's rs1 and write port.
- Returns read data or completion status on a valid/ready response channel, then releases the core.

Parameters:
- WORD_SIZE, 32, data width.
- NUM_REGS, 32, number of architectural registers.
- REG_SEL, $clog2(NUM_REGS), register index width.
- HALT_TIMEOUT, 64, maximum cycles to wait for halt_ack before an error response.
- HOLD_CYCLES, 8, cycles the core stays halted after a response, waiting for a follow-on request.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  debug request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  REG_SEL  target register.
- req_wdata  in  WORD_SIZE  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts response.
- resp_rdata  out  WORD_SIZE  read data; 0 for writes and errors.
- resp_err  out  1  timeout or out-of-range address.
- halt_req  out  1  request core halt.
- halt_ack  in  1  core is halted; held high while halted.
- rf_rs  out  REG_SEL  regfile read select (drives rs1 while halted).
- rf_rsData  in  WORD_SIZE  regfile read data (combinational from rf_rs).
- rf_wCtrl  out  1  regfile write enable.
- rf_wSel  out  REG_SEL  regfile write select.
- rf_wData  out  WORD_SIZE  regfile write data.

Behaviour:
- Reset (rst=0, async) values: state=IDLE; req_ready, resp_valid, resp_err, halt_req and rf_wCtrl all 0; resp_rdata, rf_rs, rf_wSel and rf_wData all 0; counters 0. Reset mid-transaction abandons it. halt_req drops immediately and no write is issued.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or resp_ready to any output.
- States: IDLE, HALT_WAIT, ACCESS, RESP, HOLD, RELEASE.
- IDLE: req_ready=1. On accept, latch write/addr/wdata and go to HALT_WAIT. halt_req=1 from the next cycle.
- HALT_WAIT: halt_req=1, timer increments each cycle.
  - halt_ack sampled 1 -> ACCESS.
  - Timer reaches HALT_TIMEOUT without ack -> RESP with resp_err=1 and halt_req=0. The subsequent exit goes to RELEASE.
- ACCESS: exactly one cycle.
  - Read: rf_rs=addr. rf_rsData is captured into resp_rdata at the end of this cycle.
  - Write: rf_wCtrl=1, rf_wSel=addr, rf_wData=wdata for this cycle only.
  - Write to register 0: rf_wCtrl stays 0, resp_err=0 (ignored, not an error).
  - Read of register 0 returns whatever rf_rsData gives (0).
  - addr >= NUM_REGS (only reachable when NUM_REGS is not a power of 2): no regfile access, resp_err=1.
- RESP: resp_valid=1 and fields held stable until resp_ready. On handshake:
  - if halted, go to HOLD with the hold counter reset;
  - after a timeout, go to RELEASE.
- HOLD: halt_req=1, req_ready=1, counter increments each cycle.
  - Accept -> ACCESS directly, with no second halt handshake.
  - Counter reaches HOLD_CYCLES with no request -> RELEASE.
- RELEASE: halt_req=0, req_ready=0. Wait for halt_ack=0, then go to IDLE.
- Latency, read with immediate ack: accept at edge E0 -> HALT_WAIT; ack sampled at E1 -> ACCESS; data captured at E2 -> resp_valid=1 after E2.
- Back-to-back request during HOLD: accept at E0 -> ACCESS; resp_valid after E1.
- Exactly one request is outstanding at a time. req_ready=0 in HALT_WAIT, ACCESS, RESP and RELEASE.
- halt_ack falling while in ACCESS or HOLD is a core protocol violation. The block completes the current access and takes no special action.

Decomposition:
- Shared package: state enum encoding, REG_SEL derivation, and an x0 index constant.
- One natural sub-module, dbg_sat_counter: a parameterised count-up with clear and terminal flag. It is instantiated twice, once for the halt timeout and once for the hold timer.

Test Plan:
1. Read: reg 5 preloaded with 0xDEADBEEF, halt_ack returned 1 cycle after halt_req -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept, halt_req low after HOLD_CYCLES+1.
2. Write reg 7 with 0x12345678, then read it back during HOLD -> single-cycle rf_wCtrl with rf_wSel=7; readback returns 0x12345678; halt_req stays high between the two requests (no re-handshake).
3. Write to reg 0 with 0xFFFFFFFF -> rf_wCtrl never asserts, resp_err=0; a following read of reg 0 returns 0.
4. halt_ack held 0 -> after exactly HALT_TIMEOUT=64 cycles: resp_valid=1, resp_err=1, resp_rdata=0, halt_req=0; the next request is accepted only after return to IDLE.
5. resp_ready held low 10 cycles -> resp_valid and resp_rdata stable throughout; req_ready=0 throughout.
6. rst asserted in ACCESS of a write -> rf_wCtrl and halt_req drop immediately; after release the block is in IDLE with req_ready=1 and the target register unchanged.
